// File: rtl/led_pattern_seq_pkg.sv
// Shared LED sequencer definitions: mode encodings, MiscReg field positions
// and the breathing-envelope helper.
package led_pattern_seq_pkg;

    typedef enum logic [3:0] {
        LED_MODE_OFF     = 4'd0,
        LED_MODE_ALT     = 4'd1,
        LED_MODE_SYNC    = 4'd2,
        LED_MODE_STEADY  = 4'd3,
        LED_MODE_BREATHE = 4'd4
    } led_mode_e;

    localparam int unsigned LED_MODE_LSB = 0;
    localparam int unsigned LED_MODE_MSB = 3;
    localparam int unsigned LED_BRI_LSB  = 4;
    localparam int unsigned LED_BRI_MSB  = 11;
    localparam int unsigned LED_RATE_LSB = 12;
    localparam int unsigned LED_RATE_MSB = 15;

    // Unassigned encodings fall back to OFF.
    function automatic led_mode_e led_mode_decode(input logic [3:0] raw);
        led_mode_e m;
        case (raw)
            4'd1:    m = LED_MODE_ALT;
            4'd2:    m = LED_MODE_SYNC;
            4'd3:    m = LED_MODE_STEADY;
            4'd4:    m = LED_MODE_BREATHE;
            default: m = LED_MODE_OFF;
        endcase
        return m;
    endfunction

    // Triangle envelope over one phase revolution, scaled by brightness.
    function automatic logic [7:0] breathe_duty(input logic [7:0] phase,
                                                input logic [7:0] bri);
        logic [7:0]  env;
        logic [15:0] prod;
        env  = phase[7] ? {~phase[6:0], 1'b0} : {phase[6:0], 1'b0};
        prod = 16'(env) * 16'(bri);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/led_pattern_seq_pwm_ch.sv
// One PWM LED channel: duty compare against the shared PWM counter,
// followed by the registered LED drive.
module led_pwm_ch #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_pwm_cnt,
    input  logic [W-1:0] i_duty,
    output logic         o_led
);

    logic w_on;
    logic r_led;

    // Full-scale duty is forced fully on; a plain compare would leave one
    // dark slot per period.
    assign w_on = (i_duty == '1) || (i_pwm_cnt < i_duty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_on;
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/led_pattern_seq.sv
// Registered red/green LED pattern sequencer driven by the pifctl MiscReg:
// prescaled phase accumulator, free-running PWM and per-mode duty selection.
module led_pattern_seq
    import led_pattern_seq_pkg::*;
#(
    parameter int unsigned PRESC_DIV = 24000,
    parameter int unsigned PWM_W     = 8
) (
    input  logic        xclk,
    input  logic        sys_rst,
    input  logic [31:0] misc_reg,
    output logic        ledr_o,
    output logic        ledg_o,
    output logic        tick_o,
    output logic [7:0]  phase_o
);

    localparam int unsigned         PRE_W    = $clog2(PRESC_DIV);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESC_DIV - 1);

    logic [3:0]       r_mode_q;
    logic [PWM_W-1:0] r_bri_in_q;
    logic [3:0]       r_rate_q;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [7:0]       r_phase;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [PWM_W-1:0] r_bri_q;

    logic [3:0]       w_mode_in;
    led_mode_e        w_mode;
    logic             w_restart;
    logic             w_tick;
    logic [PRE_W-1:0] w_pre_nxt;
    logic [7:0]       w_phase_nxt;
    logic [PWM_W-1:0] w_duty_r;
    logic [PWM_W-1:0] w_duty_g;
    logic             w_unused_hi;

    assign w_mode_in   = misc_reg[LED_MODE_MSB:LED_MODE_LSB];
    assign w_unused_hi = ^misc_reg[31:16];

    always_ff @(posedge xclk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_mode_q   <= '0;
            r_bri_in_q <= '0;
            r_rate_q   <= '0;
            r_pre_cnt  <= '0;
            r_phase    <= '0;
            r_pwm_cnt  <= '0;
            r_bri_q    <= '0;
        end else begin
            r_mode_q   <= w_mode_in;
            r_bri_in_q <= misc_reg[LED_BRI_MSB:LED_BRI_LSB];
            r_rate_q   <= misc_reg[LED_RATE_MSB:LED_RATE_LSB];
            r_pre_cnt  <= w_pre_nxt;
            r_phase    <= w_phase_nxt;
            r_pwm_cnt  <= r_pwm_cnt + PWM_W'(1);
            if (r_pwm_cnt == '1) begin
                r_bri_q <= r_bri_in_q;
            end
        end
    end

    // The restart is detected as the new mode is being sampled, so it lands
    // on the same edge as the mode register update and overrides a tick.
    always_comb begin
        w_mode      = led_mode_decode(r_mode_q);
        w_restart   = (w_mode_in != r_mode_q);
        w_tick      = (r_pre_cnt == PRE_LAST);
        w_pre_nxt   = r_pre_cnt + PRE_W'(1);
        w_phase_nxt = r_phase;
        w_duty_r    = '0;
        w_duty_g    = '0;

        if (w_restart) begin
            w_pre_nxt   = '0;
            w_phase_nxt = '0;
        end else if (w_tick) begin
            w_pre_nxt   = '0;
            w_phase_nxt = r_phase + 8'(r_rate_q) + 8'd1;
        end

        case (w_mode)
            LED_MODE_ALT: begin
                if (r_phase[7]) begin
                    w_duty_g = r_bri_q;
                end else begin
                    w_duty_r = r_bri_q;
                end
            end
            LED_MODE_SYNC: begin
                if (!r_phase[7]) begin
                    w_duty_r = r_bri_q;
                    w_duty_g = r_bri_q;
                end
            end
            LED_MODE_STEADY: begin
                w_duty_r = r_bri_q;
                w_duty_g = r_bri_q;
            end
            LED_MODE_BREATHE: begin
                w_duty_r = breathe_duty(r_phase, r_bri_q);
                w_duty_g = w_duty_r;
            end
            default: begin
                w_duty_r = '0;
                w_duty_g = '0;
            end
        endcase
    end

    led_pwm_ch #(.W(PWM_W)) u_red (
        .clk       (xclk),
        .rst_n     (sys_rst),
        .i_pwm_cnt (r_pwm_cnt),
        .i_duty    (w_duty_r),
        .o_led     (ledr_o)
    );

    led_pwm_ch #(.W(PWM_W)) u_green (
        .clk       (xclk),
        .rst_n     (sys_rst),
        .i_pwm_cnt (r_pwm_cnt),
        .i_duty    (w_duty_g),
        .o_led     (ledg_o)
    );

    assign tick_o  = w_tick;
    assign phase_o = r_phase;

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Downstream consumer of the pifctl MiscReg word.
- Replaces the combinational LED-pattern select in the flasher top level with a registered pattern sequencer.
- Generates PWM-dimmed, rate-controlled red/green LED drive: off, alternating, sync, steady and breathing patterns.
- Outputs feed the LEDR/LEDG output buffers directly.

Parameters:
- PRESC_DIV, 24000, xclk cycles per pattern tick (>=2); benches use 4.
- PWM_W, 8, PWM counter and duty width (fixed at 8 in this revision).

Ports:
- xclk  in  1  system clock (same clock as pifwb/pifctl).
- sys_rst  in  1  asynchronous active-low reset (GSRnX).
- misc_reg  in  32  MiscReg from pifctl. [3:0] mode, [11:4] brightness, [15:12] rate; [31:16] ignored.
- ledr_o  out  1  registered red LED drive.
- ledg_o  out  1  registered green LED drive.
- tick_o  out  1  single-cycle pattern-tick strobe (debug).
- phase_o  out  8  current pattern phase (debug).

Behaviour:
- Reset: all counters, shadow registers and outputs clear to 0 asynchronously while sys_rst=0. Reset mid-pattern restarts from phase 0.
- Mode encodings (constants LED_MODE_*):
  - OFF=0, ALT=1, SYNC=2, STEADY=3, BREATHE=4.
  - Any other value behaves as OFF.
- Input register: misc_reg fields are sampled each cycle into mode_q, bri_in_q and rate_q.
- Prescaler: pre_cnt counts 0..PRESC_DIV-1 and wraps. tick_o=1 for the one cycle where pre_cnt==PRESC_DIV-1.
- Phase:
  - On each tick, phase += rate_q+1, 8-bit modulo 256 (wrap allowed).
  - mode_q change: phase and pre_cnt clear to 0 the following cycle. Restart wins over a simultaneous tick.
- PWM:
  - pwm_cnt is an 8-bit free-running counter, incremented every xclk.
  - Brightness shadow bri_q loads from bri_in_q only when pwm_cnt==255. Changes apply at period boundaries, so there are no partial-period glitches.
- Channel on-condition: (duty==255) or (pwm_cnt < duty). duty=0 means always off; duty=255 means always on.
- Duties by mode:
  - OFF: r=0, g=0.
  - ALT: phase[7]=0 -> r=bri_q, g=0; phase[7]=1 -> r=0, g=bri_q.
  - SYNC: r=g=(phase[7]==0 ? bri_q : 0).
  - STEADY: r=g=bri_q.
  - BREATHE:
    - env = phase[7] ? {~phase[6:0],1'b0} : {phase[6:0],1'b0}.
    - duty = (env*bri_q)[15:8], using an unsigned 8x8 multiply; r=g=duty.
- Latency: duty and compare are combinational from registered state; LED outputs are registered. Outputs reflect state 1 cycle after the counter and phase update.
- A mode change reaches the outputs 2 cycles after the misc_reg change: sample cycle plus output register.
- No handshake with pifctl: misc_reg is level-held, and a write to it takes effect as described above.

Decomposition:
- pifdefs.v gets:
  - LED_MODE_OFF/ALT/SYNC/STEADY/BREATHE.
  - Field positions LED_MODE_LSB/MSB, LED_BRI_LSB/MSB and LED_RATE_LSB/MSB.
- One sub-module, led_pwm_ch, instantiated twice (red, green). It contains the duty compare (including the 255 special case) and the output register. The prescaler, phase, pwm_cnt and mode FSM stay in led_pattern_seq.

Test Plan:
- Reset and steady: hold sys_rst=0, then release with mode=OFF.
  - Required: ledr_o=ledg_o=0 and tick_o pulses every 4 cycles (PRESC_DIV=4).
  - Then STEADY with bri=255: both LEDs constant 1 from 2 cycles later.
- PWM duty: STEADY, bri=64.
  - Required: ledr_o high for exactly 64 of every 256 cycles.
  - Change bri to 128 mid-period: the new duty starts only after pwm_cnt wraps.
- ALT wrap: rate=15 (step 16).
  - Required: phase sequence 0,16,...,240,0.
  - Red active for phase<128, green for phase>=128; never both on.
- BREATHE math: bri=200.
  - Required: duty 0 at phase=0, 100 at phase=64 (env=128), 198 at phase=127 (env=254), 196 at phase=129 (env=252).
- Mode change vs tick: change mode in the same cycle tick_o=1.
  - Required: phase_o=0 and pre_cnt restarted the next cycle.
  - Undefined mode 4'hF: both LEDs 0.
- Async reset mid-BREATHE: assert sys_rst off-edge.
  - Required: outputs, phase_o and tick_o drop to 0 immediately; pattern restarts from phase 0 after release.
